// File: rtl/rom_pkg.sv
// Shared constants for the instruction-ROM port arbiter.
// Holds default widths, ROM depth and the port-select encoding.
package rom_pkg;

  localparam int unsigned ROM_SIZE   = 256;
  localparam int unsigned ROM_ADDR_W = 31;
  localparam int unsigned ROM_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic logic addr_err(
    input logic       ovf,
    input logic [1:0] lsb
  );
    return ovf | (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Saturating wait counter for the data/debug port.
// at_max signals that D has waited long enough to be forced in.
module rom_arb_starve_cnt
  import rom_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-ported instruction ROM between fetch (F) and
// data/debug (D); F has priority, D gets a forced slot after MAX_WAIT.
module rom_port_arbiter
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W   = ROM_ADDR_W,
  parameter int unsigned DATA_W   = ROM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_overflow,
  output logic              starve_evt
);

  logic at_max;
  logic frc;
  logic sel;
  logic acc_err;
  logic [DATA_W-1:0] acc_data;

  logic              f_rvalid_q, f_rvalid_d;
  logic              f_err_q, f_err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  rom_arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (d_req & ~d_gnt),
    .clr    (d_gnt | ~d_req),
    .at_max (at_max)
  );

  // Grants are masked while reset is held so nothing is accepted.
  assign frc        = d_req & at_max;
  assign d_gnt      = reset & d_req & (~f_req | frc);
  assign f_gnt      = reset & f_req & ~d_gnt;
  assign starve_evt = reset & frc & f_req;

  assign sel      = d_gnt ? PORT_D : PORT_F;
  assign rom_addr = (sel == PORT_D) ? d_addr : f_addr;
  assign acc_err  = addr_err(rom_overflow, rom_addr[1:0]);
  assign acc_data = acc_err ? '0 : rom_data;

  always_comb begin
    f_rvalid_d = f_gnt;
    f_err_d    = f_err_q;
    f_rdata_d  = f_rdata_q;
    d_rvalid_d = d_gnt;
    d_err_d    = d_err_q;
    d_rdata_d  = d_rdata_q;
    if (f_gnt) begin
      f_err_d   = acc_err;
      f_rdata_d = acc_data;
    end
    if (d_gnt) begin
      d_err_d   = acc_err;
      d_rdata_d = acc_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      f_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      f_rvalid_q <= f_rvalid_d;
      f_err_q    <= f_err_d;
      f_rdata_q  <= f_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign f_rvalid = f_rvalid_q;
  assign f_err    = f_err_q;
  assign f_rdata  = f_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: vector table, corner sequences,
// and random traffic against a cycle-level reference model.
module tb_rom_port_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [30:0] f_addr = '0;
  logic        d_req = 1'b0;
  logic [30:0] d_addr = '0;
  logic        f_gnt, f_rvalid, f_err;
  logic [31:0] f_rdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [30:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_overflow;
  logic        starve_evt;

  logic [31:0] rom [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_data     = rom[rom_addr[9:2]];
  assign rom_overflow = |rom_addr[30:10];

  rom_port_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .f_req        (f_req),
    .f_addr       (f_addr),
    .f_gnt        (f_gnt),
    .f_rvalid     (f_rvalid),
    .f_rdata      (f_rdata),
    .f_err        (f_err),
    .d_req        (d_req),
    .d_addr       (d_addr),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .rom_overflow (rom_overflow),
    .starve_evt   (starve_evt)
  );

  typedef struct {
    string       nm;
    logic        fr;
    logic [30:0] fa;
    logic        dr;
    logic [30:0] da;
    logic        fg;
    logic        dg;
    logic        st;
    logic        fv;
    logic [31:0] fd;
    logic        fe;
    logic        dv;
    logic [31:0] dd;
    logic        de;
  } vec_t;

  vec_t vt [8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic fr, logic [30:0] fa,
                       logic dr, logic [30:0] da);
    f_req  = fr;
    f_addr = fa;
    d_req  = dr;
    d_addr = da;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Reference model state
  int          m_wc;
  logic        m_fv, m_fe, m_dv, m_de;
  logic [31:0] m_fd, m_dd;

  function automatic logic is_err(logic [30:0] a);
    return (a >= 31'd1024) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] word_of(logic [30:0] a);
    return is_err(a) ? 32'h0 : rom[a[9:2]];
  endfunction

  function automatic logic [30:0] rnd_addr();
    logic [30:0] a;
    case ($urandom_range(0, 5))
      0: a = 31'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      1: a = 31'($urandom_range(256, 4000) * 4);
      default: a = 31'($urandom_range(0, 255) * 4);
    endcase
    return a;
  endfunction

  initial begin
    logic fr, dr, frc, dg, fg, st;
    logic [30:0] fa, da;

    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0800_0003;
    rom[1] = 32'h0800_0015;
    rom[2] = 32'h0800_001f;

    // Reset asserted with both requests high
    #2 reset = 1'b0;
    drive(1'b1, 31'h0, 1'b1, 31'h4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_fgnt", 32'(f_gnt), 32'd0);
      chk("rst_dgnt", 32'(d_gnt), 32'd0);
      chk("rst_fval", 32'(f_rvalid), 32'd0);
      chk("rst_dval", 32'(d_rvalid), 32'd0);
      chk("rst_starve", 32'(starve_evt), 32'd0);
    end
    @(posedge clk);
    drive(1'b0, '0, 1'b0, '0);
    #1 reset = 1'b1;

    vt[0] = '{"f_word0", 1, 31'h0, 0, 31'h0, 1, 0, 0,
              1, 32'h0800_0003, 0, 0, 32'h0, 0};
    vt[1] = '{"d_ovf", 0, 31'h0, 1, 31'h400, 0, 1, 0,
              0, 32'h0800_0003, 0, 1, 32'h0, 1};
    vt[2] = '{"f_mis", 1, 31'h2, 0, 31'h0, 1, 0, 0,
              1, 32'h0, 1, 0, 32'h0, 1};
    vt[3] = '{"f_word2", 1, 31'h8, 0, 31'h0, 1, 0, 0,
              1, 32'h0800_001f, 0, 0, 32'h0, 1};
    vt[4] = '{"f_wins", 1, 31'h0, 1, 31'h4, 1, 0, 0,
              1, 32'h0800_0003, 0, 0, 32'h0, 1};
    vt[5] = '{"d_word1", 0, 31'h0, 1, 31'h4, 0, 1, 0,
              0, 32'h0800_0003, 0, 1, 32'h0800_0015, 0};
    vt[6] = '{"idle", 0, 31'h8, 0, 31'h4, 0, 0, 0,
              0, 32'h0800_0003, 0, 0, 32'h0800_0015, 0};
    vt[7] = '{"d_mis", 0, 31'h0, 1, 31'h6, 0, 1, 0,
              0, 32'h0800_0003, 0, 1, 32'h0, 1};

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].fr, vt[i].fa, vt[i].dr, vt[i].da);
      @(negedge clk);
      chk({vt[i].nm, "_fgnt"}, 32'(f_gnt), 32'(vt[i].fg));
      chk({vt[i].nm, "_dgnt"}, 32'(d_gnt), 32'(vt[i].dg));
      chk({vt[i].nm, "_st"}, 32'(starve_evt), 32'(vt[i].st));
      chk({vt[i].nm, "_addr"}, 32'(rom_addr),
          32'(vt[i].dg ? vt[i].da : vt[i].fa));
      @(posedge clk);
      #1;
      chk({vt[i].nm, "_fv"}, 32'(f_rvalid), 32'(vt[i].fv));
      chk({vt[i].nm, "_fd"}, f_rdata, vt[i].fd);
      chk({vt[i].nm, "_fe"}, 32'(f_err), 32'(vt[i].fe));
      chk({vt[i].nm, "_dv"}, 32'(d_rvalid), 32'(vt[i].dv));
      chk({vt[i].nm, "_dd"}, d_rdata, vt[i].dd);
      chk({vt[i].nm, "_de"}, 32'(d_err), 32'(vt[i].de));
    end

    // Starvation guard: both held, D forced in cycle MAXW
    drive(1'b1, 31'h0, 1'b1, 31'h4);
    for (int c = 0; c <= MAXW; c++) begin
      @(negedge clk);
      chk($sformatf("starve_c%0d_dg", c), 32'(d_gnt),
          32'(c == MAXW));
      chk($sformatf("starve_c%0d_fg", c), 32'(f_gnt),
          32'(c != MAXW));
      chk($sformatf("starve_c%0d_st", c), 32'(starve_evt),
          32'(c == MAXW));
      @(posedge clk);
      #1;
    end
    chk("starve_dv", 32'(d_rvalid), 32'd1);
    chk("starve_dd", d_rdata, 32'h0800_0015);
    chk("starve_fv", 32'(f_rvalid), 32'd0);
    @(negedge clk);
    chk("starve_f_again", 32'(f_gnt), 32'd1);
    chk("starve_d_wait", 32'(d_gnt), 32'd0);
    @(posedge clk);

    // Random traffic vs reference model
    do_reset();
    m_wc = 0;
    {m_fv, m_fe, m_dv, m_de} = '0;
    m_fd = '0;
    m_dd = '0;
    for (int c = 0; c < 600; c++) begin
      fr = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      fa = rnd_addr();
      da = rnd_addr();
      drive(fr, fa, dr, da);
      frc = dr && (m_wc == MAXW);
      dg  = dr && (!fr || frc);
      fg  = fr && !dg;
      st  = frc && fr;
      @(negedge clk);
      chk("rnd_fgnt", 32'(f_gnt), 32'(fg));
      chk("rnd_dgnt", 32'(d_gnt), 32'(dg));
      chk("rnd_st", 32'(starve_evt), 32'(st));
      chk("rnd_addr", 32'(rom_addr), 32'(dg ? da : fa));
      @(posedge clk);
      #1;
      m_fv = fg;
      m_dv = dg;
      if (fg) begin
        m_fe = is_err(fa);
        m_fd = word_of(fa);
      end
      if (dg) begin
        m_de = is_err(da);
        m_dd = word_of(da);
      end
      if (dg || !dr) m_wc = 0;
      else if (m_wc < MAXW) m_wc = m_wc + 1;
      chk("rnd_fv", 32'(f_rvalid), 32'(m_fv));
      chk("rnd_fd", f_rdata, m_fd);
      chk("rnd_fe", 32'(f_err), 32'(m_fe));
      chk("rnd_dv", 32'(d_rvalid), 32'(m_dv));
      chk("rnd_dd", d_rdata, m_dd);
      chk("rnd_de", 32'(d_err), 32'(m_de));
    end

    // Reset lands while a D response is in flight
    drive(1'b0, 31'h0, 1'b1, 31'h4);
    @(negedge clk);
    chk("mid_dgnt", 32'(d_gnt), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_dv_now", 32'(d_rvalid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("mid_dv_rst", 32'(d_rvalid), 32'd0);
      chk("mid_dd_rst", d_rdata, 32'h0);
      drive(1'b0, '0, 1'b0, '0);
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("mid_dv_post", 32'(d_rvalid), 32'd0);
    end
    drive(1'b1, 31'h0, 1'b0, '0);
    @(negedge clk);
    chk("post_fgnt", 32'(f_gnt), 32'd1);
    @(posedge clk);
    #1;
    chk("post_fv", 32'(f_rvalid), 32'd1);
    chk("post_fd", f_rdata, 32'h0800_0003);
    chk("post_fe", 32'(f_err), 32'd0);
    chk("post_dv", 32'(d_rvalid), 32'd0);
    drive(1'b0, '0, 1'b0, '0);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
